// File: rtl/cam_core.sv
// cam_core: content-addressable memory with a fixed IDLE -> CMP -> RESP pass
// per operation. Writes store din at entry addr unless the key already lives
// at a different entry. Searches return the lowest matching entry index.
//
// Optional build macro: CAM_MULTI_HIT_EN adds the multi_hit output.
//
// Ports:
//   clk                  system clock, rising edge
//   rst                  asynchronous reset, active-low
//   req                  operation request, sampled only in IDLE
//   wr_nrd               1 = write, 0 = search
//   din                  write data or search key
//   addr                 write target entry (ignored for search)
//   dout                 search result index, zero-extended, 0 on miss
//   read_valid           one-cycle pulse, search result valid
//   hit                  search found a match (qualifies read_valid)
//   busy                 FSM not IDLE
//   full                 all entries valid
//   almost_full          valid count >= DEPTH - AF_MARGIN
//   write_error          one-cycle pulse, write rejected as duplicate
//   invalid_write_state  one-cycle pulse, write requested while busy, dropped
//   multi_hit            (CAM_MULTI_HIT_EN only) more than one entry matched
module cam_core #(
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned WIDTH_ADDR = 4,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr_nrd,
  input  logic [WIDTH_DATA-1:0] din,
  input  logic [WIDTH_ADDR-1:0] addr,
  output logic [WIDTH_DATA-1:0] dout,
  output logic                  read_valid,
  output logic                  hit,
  output logic                  busy,
  output logic                  full,
  output logic                  almost_full,
  output logic                  write_error,
`ifdef CAM_MULTI_HIT_EN
  output logic                  multi_hit,
`endif
  output logic                  invalid_write_state
);

  localparam int unsigned DEPTH = 2 ** WIDTH_ADDR;
  localparam int unsigned CNT_W = WIDTH_ADDR + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_op_wr;
  logic [WIDTH_DATA-1:0] r_key;
  logic [WIDTH_ADDR-1:0] r_addr;
  logic [WIDTH_DATA-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [CNT_W-1:0]      r_count;

  logic [DEPTH-1:0]      w_match;
  logic [DEPTH-1:0]      w_addr_oh;
  logic [WIDTH_ADDR-1:0] w_low;
  logic                  w_conflict;
  logic                  w_do_write;
  logic [CNT_W-1:0]      w_count_nxt;

  // Parallel compare of the latched key against every valid entry.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_match[i] = r_valid[i] && (r_data[i] == r_key);
    end
  end

  // Lowest-index priority encoder: scan downward so the lowest match wins.
  always_comb begin
    w_low = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_low = WIDTH_ADDR'(i);
      end
    end
  end

  // A write is a duplicate only if the key already sits at some other entry;
  // a match at the target entry itself is a legal rewrite.
  always_comb begin
    w_addr_oh   = DEPTH'(1) << r_addr;
    w_conflict  = |(w_match & ~w_addr_oh);
    w_do_write  = (r_state == S_CMP) && r_op_wr && !w_conflict;
    w_count_nxt = r_count + CNT_W'(!r_valid[r_addr]);
  end

  // Entry storage has no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_data[r_addr] <= r_key;
    end
  end

  // Operation FSM with registered status and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= S_IDLE;
      r_op_wr             <= 1'b0;
      r_key               <= '0;
      r_addr              <= '0;
      r_valid             <= '0;
      r_count             <= '0;
      dout                <= '0;
      read_valid          <= 1'b0;
      hit                 <= 1'b0;
      busy                <= 1'b0;
      full                <= 1'b0;
      almost_full         <= 1'b0;
      write_error         <= 1'b0;
      invalid_write_state <= 1'b0;
`ifdef CAM_MULTI_HIT_EN
      multi_hit           <= 1'b0;
`endif
    end else begin
      read_valid          <= 1'b0;
      write_error         <= 1'b0;
      invalid_write_state <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_op_wr <= wr_nrd;
            r_key   <= din;
            r_addr  <= addr;
            r_state <= S_CMP;
            busy    <= 1'b1;
          end
        end
        S_CMP: begin
          invalid_write_state <= req && wr_nrd;
          r_state             <= S_RESP;
          if (r_op_wr) begin
            if (w_conflict) begin
              write_error <= 1'b1;
            end else begin
              r_valid[r_addr] <= 1'b1;
              r_count         <= w_count_nxt;
              full            <= (w_count_nxt == CNT_W'(DEPTH));
              almost_full     <= (w_count_nxt >= CNT_W'(DEPTH - AF_MARGIN));
            end
          end else begin
            read_valid <= 1'b1;
            hit        <= |w_match;
            dout       <= WIDTH_DATA'(w_low);
`ifdef CAM_MULTI_HIT_EN
            // Clearing the lowest set bit leaves something only if >1 matched.
            multi_hit  <= |(w_match & (w_match - DEPTH'(1)));
`endif
          end
        end
        S_RESP: begin
          invalid_write_state <= req && wr_nrd;
          r_state             <= S_IDLE;
          busy                <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_core.sv
// Directed bench for cam_core. Stimulus pushes expected pulse events into a
// scoreboard queue; a monitor pops and compares on every response pulse.
module tb_cam_core;

  logic       clk;
  logic       rst;
  logic       req;
  logic       wr_nrd;
  logic [7:0] din;
  logic [3:0] addr;
  logic [7:0] dout;
  logic       read_valid;
  logic       hit;
  logic       busy;
  logic       full;
  logic       almost_full;
  logic       write_error;
  logic       invalid_write_state;
`ifdef CAM_MULTI_HIT_EN
  logic       multi_hit;
`endif

  cam_core #(
    .WIDTH_DATA(8),
    .WIDTH_ADDR(4),
    .AF_MARGIN (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req                (req),
    .wr_nrd             (wr_nrd),
    .din                (din),
    .addr               (addr),
    .dout               (dout),
    .read_valid         (read_valid),
    .hit                (hit),
    .busy               (busy),
    .full               (full),
    .almost_full        (almost_full),
    .write_error        (write_error),
`ifdef CAM_MULTI_HIT_EN
    .multi_hit          (multi_hit),
`endif
    .invalid_write_state(invalid_write_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = search result, 1 = write_error pulse, 2 = invalid_write_state pulse
  typedef struct {
    int         kind;
    logic       hit;
    logic [7:0] dout;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end else begin
      n_pass++;
    end
  endfunction

  function automatic void push(input int kind, input logic h, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.hit  = h;
    e.dout = d;
    q.push_back(e);
  endfunction

  // Monitor: every response pulse must match the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (read_valid) begin
      chk("sb_nonempty_rv", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_kind_rv", 32'(e.kind), 32'd0);
        chk("sb_hit", 32'(hit), 32'(e.hit));
        chk("sb_dout", 32'(dout), 32'(e.dout));
      end
    end
    if (write_error) begin
      chk("sb_nonempty_we", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_kind_we", 32'(e.kind), 32'd1);
      end
    end
    if (invalid_write_state) begin
      chk("sb_nonempty_iws", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_kind_iws", 32'(e.kind), 32'd2);
      end
    end
  end

  // One full operation: accepted at edge T, returns just after edge T+2.
  task automatic op(input logic wr, input logic [7:0] d, input logic [3:0] a);
    @(negedge clk);
    req    = 1'b1;
    wr_nrd = wr;
    din    = d;
    addr   = a;
    @(negedge clk);
    req    = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d, input logic [3:0] a, input logic err);
    if (err) push(1, 1'b0, 8'h00);
    op(1'b1, d, a);
  endtask

  task automatic do_search(input logic [7:0] key, input logic h, input logic [7:0] d);
    push(0, h, d);
    op(1'b0, key, 4'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_read_valid"}, 32'(read_valid), 32'd0);
    chk({tag, "_hit"}, 32'(hit), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, "_write_error"}, 32'(write_error), 32'd0);
    chk({tag, "_iws"}, 32'(invalid_write_state), 32'd0);
  endtask

  initial begin
    rst    = 1'b0;
    req    = 1'b0;
    wr_nrd = 1'b0;
    din    = 8'h00;
    addr   = 4'h0;
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Empty CAM search misses.
    do_search(8'h00, 1'b0, 8'h00);
    chk("empty_full", 32'(full), 32'd0);
    chk("empty_af", 32'(almost_full), 32'd0);

    // Basic write and search.
    do_write(8'h5A, 4'd3, 1'b0);
    do_write(8'hA5, 4'd7, 1'b0);
    do_search(8'hA5, 1'b1, 8'd7);
    do_search(8'h11, 1'b0, 8'h00);

    // Duplicate key at a different entry is rejected; original stays.
    do_write(8'h5A, 4'd9, 1'b1);
    do_search(8'h5A, 1'b1, 8'd3);
    // Same data rewritten at the same entry is legal.
    do_write(8'h5A, 4'd3, 1'b0);
    do_search(8'h5A, 1'b1, 8'd3);

    // Fill from empty: almost_full after 14th write, full after 16th.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      do_write(8'h10 + 8'(i), 4'(i), 1'b0);
      chk($sformatf("fill%0d_af", i + 1), 32'(almost_full), 32'(i + 1 >= 14));
      chk($sformatf("fill%0d_full", i + 1), 32'(full), 32'(i + 1 == 16));
    end
    do_write(8'h77, 4'd4, 1'b0);
    chk("overwrite_full", 32'(full), 32'd1);
    do_search(8'h77, 1'b1, 8'd4);
    do_search(8'h14, 1'b0, 8'h00);
    do_search(8'h1F, 1'b1, 8'd15);

    // Write request while busy is dropped and flagged.
    pulse_reset();
    push(2, 1'b0, 8'h00);
    @(negedge clk);
    req    = 1'b1;
    wr_nrd = 1'b1;
    din    = 8'h33;
    addr   = 4'd1;
    @(negedge clk);
    chk("busy_t1", 32'(busy), 32'd1);
    din  = 8'h44;
    addr = 4'd2;
    @(negedge clk);
    req = 1'b0;
    chk("busy_t2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_t3", 32'(busy), 32'd0);
    do_search(8'h44, 1'b0, 8'h00);
    do_search(8'h33, 1'b1, 8'd1);

    // Reset during CMP of a write aborts it.
    @(negedge clk);
    req    = 1'b1;
    wr_nrd = 1'b1;
    din    = 8'h66;
    addr   = 4'd5;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    do_search(8'h66, 1'b0, 8'h00);
    do_search(8'h33, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cam_core.md
Name: cam_core

Overview:
- Content-addressable memory that sits directly downstream of the CAM drive interface and consumes its req/wr_nrd/din/addr bundle.
- Returns dout, read_valid, busy, full, almost_full, write_error and invalid_write_state to that interface.
- Writes store din at entry addr.
- Searches compare din against all valid entries in parallel and return the lowest matching index.
- Every operation is a fixed 3-state FSM pass with registered compare and response stages.

Parameters:
- WIDTH_DATA, 8, data/key width; tied to param_WIDTH_DATA at instantiation.
- WIDTH_ADDR, 4, entry index width; tied to param_WIDTH_ADDR.
- DEPTH, 2**WIDTH_ADDR, number of entries (derived, not overridden).
- AF_MARGIN, 2, almost_full asserts when valid count >= DEPTH-AF_MARGIN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req  in  1  operation request, sampled only in IDLE.
- wr_nrd  in  1  1=write, 0=search.
- din  in  WIDTH_DATA  write data or search key.
- addr  in  WIDTH_ADDR  write target entry; ignored for search.
- dout  out  WIDTH_DATA  search result index, zero-extended; 0 on miss.
- read_valid  out  1  one-cycle pulse, search result valid.
- hit  out  1  qualifies read_valid: 1=match found.
- busy  out  1  high whenever FSM is not IDLE.
- full  out  1  all DEPTH entries valid.
- almost_full  out  1  valid count >= DEPTH-AF_MARGIN.
- write_error  out  1  one-cycle pulse, write rejected as duplicate.
- invalid_write_state  out  1  one-cycle pulse, write requested while busy and dropped.

Behaviour:
- Reset (rst=0, asynchronous): all valid bits, count, FSM (IDLE) and every output go to 0. Entry data contents are don't-care. Reset mid-operation aborts the operation with no partial write.
- Storage: DEPTH x WIDTH_DATA data array, DEPTH valid bits, count register of WIDTH_ADDR+1 bits.
- FSM states: IDLE -> CMP -> RESP -> IDLE. No stalls; every accepted operation takes exactly 3 edges.
- IDLE: on an edge with req=1, latch op/din/addr and go to CMP.
- CMP: register match vector m[i] = valid[i] && (data[i]==key), then go to RESP.
- RESP: return to IDLE on the next edge.
- busy = (state != IDLE), registered. A request accepted at edge T gives busy=1 for cycles T+1 and T+2; the next request is accepted at edge T+3.
- Search result, presented in RESP (cycle T+2):
  - read_valid=1 for exactly one cycle.
  - On any m bit set: hit=1, dout = lowest set index.
  - On no match: hit=0, dout=0.
  - dout/hit hold until the next search result.
- Write, resolved on the CMP->RESP edge:
  - If m has a bit set at any index other than addr: write_error=1 for the RESP cycle and storage is unchanged.
  - Otherwise: data[addr]=din and valid[addr]=1. count increments only if valid[addr] was 0.
  - Rewriting identical data at the same addr is legal; no error, count unchanged.
  - full/almost_full update on the same edge.
- Writes have no read_valid; searches have no write_error.
- Write to a full CAM at an already-valid addr is an overwrite and is legal. A full CAM always has all addresses valid, so there is no "full" rejection.
- Request while busy:
  - Write: dropped; invalid_write_state=1 for the following cycle (one pulse per offending cycle).
  - Search: silently dropped.
- Search when count=0: miss, hit=0, dout=0.
- Multiple matches can only occur via overwrite history; the lowest index wins.

Optional Feature:
- Macro: CAM_MULTI_HIT_EN.
- Defined: adds output port multi_hit (1 bit). It is set with read_valid when more than one m bit is set and is 0 at reset.
- Undefined: port is absent; lowest-index priority encoding is unchanged.

Test Plan:
- Reset then search key 0x00 -> read_valid pulse at T+2, hit=0, dout=0, full=0, almost_full=0.
- Write 0x5A@3, 0xA5@7, then search 0xA5 -> hit=1, dout=7; search 0x11 -> hit=0.
- Write 0x5A@3, then write 0x5A@9 -> write_error pulse in RESP; search 0x5A returns dout=3; count unchanged.
- Write 16 distinct values to addr 0..15 -> almost_full rises after the 14th write, full after the 16th. Then rewrite addr 4 with a new value -> full stays 1, no error.
- Write accepted at T, second write req at T+1 -> invalid_write_state=1 at T+2, second data not stored; busy=1 exactly at T+1..T+2.
- Assert rst low during CMP of a write -> all outputs 0 immediately; post-reset search of that data misses.
